vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 VGA timing from the 50 MHz board clock: 25 MHz pixel clock
//  (vgaclock), hsync, vsync, n_blank and the current pixel coordinate.
//  Sits directly upstream of the pixel/colour stage in main. That stage consumes x/y/pixel_tick
//  to produce red_out/green_out/blue_out. The sync/blank outputs go straight to the DAC pins.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync pulse width (pixels)
//  H_BP       48   horizontal back porch (pixels); H_TOTAL = 800
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines); V_TOTAL = 525
//  SYNC_POL   0    active level of hsync/vsync pulses (0 = active-low)
// PORTS
//  clock_50    in   1   50 MHz system clock
//  reset       in   1   asynchronous, active-high reset
//  vgaclock    out  1   25 MHz pixel clock to DAC (clock_50 / 2)
//  pixel_tick  out  1   1-cycle (clock_50) enable; counters advance on this cycle
//  hsync       out  1   horizontal sync, polarity per SYNC_POL
//  vsync       out  1   vertical sync, polarity per SYNC_POL
//  n_blank     out  1   1 = active video, 0 = blanking (DAC BLANK_N)
//  x           out  11  horizontal count 0..H_TOTAL-1
//  y           out  11  vertical count 0..V_TOTAL-1
//  frame_start out  1   1-cycle pulse when (x,y) becomes (0,0)
//  line_start  out  1   1-cycle pulse when x becomes 0
// BEHAVIOUR
//  - All state on posedge clock_50 or posedge reset. All outputs are registered.
//  - Reset values:
//    - vgaclock=0, pixel_tick=0, x=0, y=0, n_blank=1.
//    - hsync=vsync=~SYNC_POL (inactive), frame_start=0, line_start=0.
//  - Divider: a phase flop toggles every clock_50 cycle, and vgaclock = phase.
//    - pixel_tick=1 in the cycle where phase==1. That gives one tick per two clock_50 cycles.
//    - The first tick comes in the second cycle after reset is released.
//  - The counter state machine is a 2-D counter and advances only when pixel_tick is 1.
//    - x: if x==H_TOTAL-1, x<=0; otherwise x<=x+1.
//    - y: when x wraps, y<=(y==V_TOTAL-1) ? 0 : y+1. Otherwise y holds.
//  - Decode: hsync/vsync/n_blank are computed from the next (x,y) and registered with them.
//    All outputs therefore describe the same pixel in every cycle (zero skew, no extra latency).
//    - hsync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
//    - vsync active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
//    - n_blank=1 iff x<H_ACTIVE && y<V_ACTIVE.
//  - line_start/frame_start assert only in the cycle where the wrapping tick occurs.
//    - frame_start implies line_start.
//    - Neither pulses on reset release.
//  - Reset mid-frame: everything returns asynchronously to the reset values. There is no partial-line output.
//  - Counter width is 11 bits and must hold H_TOTAL-1 and V_TOTAL-1.
//    Compare with >= on the wrap terminal so an illegal count (SEU, bad parameter) recovers to 0.
// STRUCTURE
//  - Package vga_pkg: the default timing localparams (H_*/V_*, H_TOTAL, V_TOTAL) and a
//    typedef logic [10:0] coord_t for x/y. The pixel stage shares this package.
//  - One sub-module, mod_counter #(MAX): an enable-gated wrap counter with a wrap-pulse output.
//    It is instantiated twice, with the h-wrap pulse gating the v counter.
//  - Sync/blank decode stays inline.
// TESTING
//  - Reset held 5 cycles then released:
//    - all outputs at reset values during reset;
//    - vgaclock toggles every cycle;
//    - pixel_tick every 2nd cycle, first at cycle 2.
//  - Free run one line:
//    - hsync goes active at x=656 and inactive at x=752 (96 ticks);
//    - n_blank falls at x=640;
//    - line_start pulses with x=0 after 800 ticks.
//  - Free run a full frame:
//    - vsync active exactly for y=490,491;
//    - n_blank=0 for all y>=480;
//    - frame_start pulses once per 420000 ticks (840000 clock_50 cycles).
//  - Golden dump: count clock_50 cycles, and compare hsync/vsync/n_blank/x/y per tick against a
//    reference model over 2 frames. The reference model is an independent loop over y 0..524 and x 0..799.
//  - Assert reset at x=700, y=491 (hsync and vsync active):
//    - same cycle: hsync=vsync=inactive, x=y=0;
//    - after release, the sequence restarts identically.
//  - SYNC_POL=1 instance: pulses are high over the same x/y windows; n_blank unchanged.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, coordinate type and a
// window-decode helper. The downstream pixel stage imports this package as well.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam int COORD_W  = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_win(coord_t v, int lo, int hi);
    return (v >= coord_t'(lo)) && (v < coord_t'(hi));
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the generator to the pixel stage and the DAC pins.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   vgaclock;
  logic   pixel_tick;
  logic   hsync;
  logic   vsync;
  logic   n_blank;
  coord_t x;
  coord_t y;
  logic   frame_start;
  logic   line_start;

  modport master (output vgaclock, pixel_tick, hsync, vsync, n_blank,
                         x, y, frame_start, line_start);
  modport slave  (input  vgaclock, pixel_tick, hsync, vsync, n_blank,
                         x, y, frame_start, line_start);
endinterface

// File: rtl/vga_timing_gen_counter.sv
// Enable-gated modulo counter. cnt_d is the value loaded at the next edge, so
// callers can decode the upcoming count and register it alongside cnt.
// The terminal test uses >= so an out-of-range count recovers to 0.
module mod_counter
  import vga_pkg::*;
#(
  parameter int MAX = 800
)(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t cnt,
  output coord_t cnt_d,
  output logic   wrap
);
  localparam coord_t LAST = coord_t'(MAX - 1);

  logic term;

  assign term  = (cnt >= LAST);
  assign wrap  = en & term;
  assign cnt_d = !en ? cnt : (term ? '0 : cnt + coord_t'(1));

  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides the 50 MHz clock to a 25 MHz pixel rate and
// produces registered sync/blank/coordinate outputs that all describe the same
// pixel in every cycle. Counters move on the edge that closes a tick cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
)(
  input  logic              clock_50,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);
  import vga_pkg::*;

  localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  logic   phase;
  logic   h_wrap, v_wrap;
  coord_t x_q, x_d, y_q, y_d;
  logic   hsync_q, vsync_q, n_blank_q, line_start_q, frame_start_q;

  // divide-by-two phase; high half is the pixel tick
  always_ff @(posedge clock_50 or posedge reset)
    if (reset) phase <= 1'b0;
    else       phase <= ~phase;

  mod_counter #(.MAX(H_TOT)) u_hcnt (
    .clk(clock_50), .rst(reset), .en(phase),
    .cnt(x_q), .cnt_d(x_d), .wrap(h_wrap)
  );

  mod_counter #(.MAX(V_TOT)) u_vcnt (
    .clk(clock_50), .rst(reset), .en(h_wrap),
    .cnt(y_q), .cnt_d(y_d), .wrap(v_wrap)
  );

  // decode the upcoming coordinate so sync/blank land with x/y
  always_ff @(posedge clock_50 or posedge reset)
    if (reset) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      n_blank_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= in_win(x_d, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= in_win(y_d, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      n_blank_q     <= (x_d < coord_t'(H_ACTIVE)) && (y_d < coord_t'(V_ACTIVE));
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
    end

  assign vga.vgaclock    = phase;
  assign vga.pixel_tick  = phase;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.n_blank     = n_blank_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus two reduced-timing
// instances (active-low and active-high sync) checked per sample against a
// pixel-index reference model.
module tb_vga_timing_gen;
  // reduced timing: 8+2+3+3 = 16 pixels, 6+2+2+2 = 12 lines
  localparam int S_HT = 16;
  localparam int S_VT = 12;
  localparam int S_FRAME_CYC = S_HT * S_VT * 2;  // 384 clocks per frame

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fs = -1;
  int   n_gaps = 0;
  int   hs_cnt = 0;

  vga_timing_gen_if d_if();
  vga_timing_gen_if s_if();
  vga_timing_gen_if p_if();

  vga_timing_gen dut_d (.clock_50(clk), .reset(reset), .vga(d_if));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut_s (.clock_50(clk), .reset(reset), .vga(s_if));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) dut_p (.clock_50(clk), .reset(reset), .vga(p_if));

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // frame_start spacing on the reduced instance
  always @(negedge clk) begin
    if (reset) last_fs <= -1;
    else if (s_if.frame_start) begin
      if (last_fs >= 0) begin
        chk("s_fs_gap", cyc - last_fs, S_FRAME_CYC);
        n_gaps <= n_gaps + 1;
      end
      last_fs <= cyc;
    end
  end

  // Reference: pixel index p maps to (p % H_TOTAL, p / H_TOTAL); t is the
  // expected tick level; st marks the first sample of a freshly entered pixel.
  task automatic chk_pix(input int p, input logic t, input logic st);
    int sx, sy, dx, dy;
    logic s_hs, s_vs, s_nb, d_hs, d_vs, d_nb;
    sx = p % S_HT;
    sy = (p / S_HT) % S_VT;
    dx = p % 800;
    dy = (p / 800) % 525;
    s_hs = (sx >= 10) && (sx < 13);
    s_vs = (sy >= 8) && (sy < 10);
    s_nb = (sx < 8) && (sy < 6);
    d_hs = (dx >= 656) && (dx < 752);
    d_vs = (dy >= 490) && (dy < 492);
    d_nb = (dx < 640) && (dy < 480);
    chk("tick",   s_if.pixel_tick, t);
    chk("vgaclk", d_if.vgaclock, t);
    chk("s_x",    s_if.x, sx);
    chk("s_y",    s_if.y, sy);
    chk("s_hs",   s_if.hsync, !s_hs);
    chk("s_vs",   s_if.vsync, !s_vs);
    chk("s_nb",   s_if.n_blank, s_nb);
    chk("s_ls",   s_if.line_start, st && sx == 0);
    chk("s_fs",   s_if.frame_start, st && sx == 0 && sy == 0);
    chk("p_hs",   p_if.hsync, s_hs);
    chk("p_vs",   p_if.vsync, s_vs);
    chk("p_nb",   p_if.n_blank, s_nb);
    chk("d_x",    d_if.x, dx);
    chk("d_y",    d_if.y, dy);
    chk("d_hs",   d_if.hsync, !d_hs);
    chk("d_vs",   d_if.vsync, !d_vs);
    chk("d_nb",   d_if.n_blank, d_nb);
    chk("d_ls",   d_if.line_start, st && dx == 0);
    chk("d_fs",   d_if.frame_start, st && dx == 0 && dy == 0);
    if (t && dy == 0 && !d_if.hsync) hs_cnt++;
  endtask

  // each pixel spans two clocks: tick low (just advanced), then tick high
  task automatic run_pixels(input int p0, input int p1);
    for (int p = p0; p <= p1; p++) begin
      @(negedge clk); chk_pix(p, 1'b0, 1'b1);
      @(negedge clk); chk_pix(p, 1'b1, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vgaclk"}, d_if.vgaclock, 0);
    chk({tag, "_tick"},   d_if.pixel_tick, 0);
    chk({tag, "_x"},      d_if.x, 0);
    chk({tag, "_y"},      d_if.y, 0);
    chk({tag, "_nb"},     d_if.n_blank, 1);
    chk({tag, "_hs"},     d_if.hsync, 1);
    chk({tag, "_vs"},     d_if.vsync, 1);
    chk({tag, "_ls"},     d_if.line_start, 0);
    chk({tag, "_fs"},     d_if.frame_start, 0);
    chk({tag, "_s_x"},    s_if.x, 0);
    chk({tag, "_s_y"},    s_if.y, 0);
    chk({tag, "_s_hs"},   s_if.hsync, 1);
    chk({tag, "_s_vs"},   s_if.vsync, 1);
    chk({tag, "_p_hs"},   p_if.hsync, 0);
    chk({tag, "_p_vs"},   p_if.vsync, 0);
    chk({tag, "_p_nb"},   p_if.n_blank, 1);
  endtask

  initial begin
    repeat (5) begin
      @(negedge clk);
      chk_reset_vals("rst");
    end
    reset = 1'b0;

    // first tick right after release shows pixel (0,0), no start pulses
    @(negedge clk); chk_pix(0, 1'b1, 1'b0);
    // four+ reduced frames and the first default line wrap, ending at
    // reduced (11,9): hsync and vsync both active
    run_pixels(1, 923);
    chk("d_hs_width", hs_cnt, 96);
    chk("s_fs_gaps", n_gaps, 3);
    chk("s_mid_hs", s_if.hsync, 0);
    chk("s_mid_vs", s_if.vsync, 0);

    // asynchronous reset mid-pixel, checked before the next clock edge
    #2 reset = 1'b1;
    #1 chk_reset_vals("amid");

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); chk_pix(0, 1'b1, 1'b0);
    run_pixels(1, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
